// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter: FSM state encoding and stats width.
package stream_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int STATS_WIDTH = 32;

endpackage

// File: rtl/stream_arbiter_pick.sv
// Wrap-around first-valid search: returns the first requesting index at or
// after i_ptr, visiting i_ptr, i_ptr+1, ..., N-1, 0, ... in that order.
module rr_priority_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_vld
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;

  // Rotate so the pointer position lands on bit 0; the lowest set bit is then the winner.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector (scan downward so the smallest index wins).
  always_comb begin
    o_vld = 1'b0;
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_vld = 1'b1;
        w_off = W'(j);
      end
    end
  end

  // Undo the rotation, wrapping modulo N.
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (W + 1)'(N)) ? W'(w_sum - (W + 1)'(N)) : w_sum[W-1:0];

endmodule

// File: rtl/stream_arbiter.sv
// Packet-aware round-robin merge of N_STREAMS valid/ready streams onto one
// registered output. A stream that starts a multi-beat packet keeps the grant
// until its last beat; the round-robin pointer moves only on a last beat.
// Optional per-stream accepted-beat counters: define STREAM_ARBITER_STATS_EN.
//
//   state      | meaning
//   ARB_IDLE   | no packet in progress; grant by round-robin search from rr_ptr
//   ARB_LOCKED | mid-packet; grant pinned to lock_idx until its last beat
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int  N_STREAMS = 2,
  parameter type DATA_TYPE = logic [63:0],
  parameter int  N_BITS    = $clog2(N_STREAMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  DATA_TYPE             i_data [N_STREAMS],
  input  logic [N_STREAMS-1:0] i_valid,
  input  logic [N_STREAMS-1:0] i_last,
  output logic [N_STREAMS-1:0] i_ready,
  output DATA_TYPE             o_data,
  output logic                 o_valid,
  output logic                 o_last,
  output logic [N_BITS-1:0]    o_sel,
  input  logic                 o_ready
`ifdef STREAM_ARBITER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] beat_count [N_STREAMS]
`endif
);

  arb_state_t        r_state, w_state_nxt;
  logic [N_BITS-1:0] r_rr_ptr, w_rr_nxt;
  logic [N_BITS-1:0] r_lock_idx, w_lock_nxt;
  logic [N_BITS-1:0] w_pick_idx, w_gnt;
  logic              w_pick_vld, w_gnt_vld;
  logic              w_can_load, w_accept;

  DATA_TYPE          r_data;
  logic              r_valid, r_last;
  logic [N_BITS-1:0] r_sel;

  rr_priority_pick #(
    .N (N_STREAMS),
    .W (N_BITS)
  ) u_pick (
    .i_req (i_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // The output register can take a beat when empty or being drained this cycle.
  assign w_can_load = !r_valid || o_ready;

  // Grant selection, accept decision and next FSM/pointer/lock values.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_idx;
    w_gnt       = w_pick_idx;
    w_gnt_vld   = w_pick_vld;
    if (r_state == ARB_LOCKED) begin
      w_gnt     = r_lock_idx;
      w_gnt_vld = i_valid[r_lock_idx];
    end
    w_accept = w_gnt_vld && w_can_load && !rst;
    if (w_accept) begin
      if (i_last[w_gnt]) begin
        w_state_nxt = ARB_IDLE;
        w_rr_nxt    = (w_gnt == N_BITS'(N_STREAMS - 1)) ? '0 : w_gnt + N_BITS'(1);
      end else begin
        w_state_nxt = ARB_LOCKED;
        w_lock_nxt  = w_gnt;
      end
    end
  end

  assign i_ready = w_accept ? (N_STREAMS'(1) << w_gnt) : '0;

  // FSM state, round-robin pointer and packet lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_idx <= w_lock_nxt;
    end
  end

  // Registered output stage; holds its contents while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sel   <= '0;
      r_data  <= '0;
    end else if (w_can_load) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data <= i_data[w_gnt];
        r_last <= i_last[w_gnt];
        r_sel  <= w_gnt;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_sel   = r_sel;

`ifdef STREAM_ARBITER_STATS_EN
  for (genvar k = 0; k < N_STREAMS; k++) begin : g_stats
    logic [STATS_WIDTH-1:0] r_cnt;

    // Saturating count of beats accepted from stream k.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (i_ready[k] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign beat_count[k] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter (N_STREAMS=4) with a packet-level
// reference model plus directed scenarios and a randomized phase.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int NB = 2;
  typedef logic [63:0] data_t;

  logic           clk = 1'b0;
  logic           rst;
  data_t          i_data [N];
  logic [N-1:0]   i_valid, i_last, i_ready;
  data_t          o_data;
  logic           o_valid, o_last, o_ready;
  logic [NB-1:0]  o_sel;
`ifdef STREAM_ARBITER_STATS_EN
  logic [31:0]    beat_count [N];
`endif

  int total = 0;
  int bad   = 0;
  int q_sel[$];
  int exp_q[$];

  // Reference model state: output register contents, lock, round-robin pointer.
  bit     m_valid, m_last, m_locked;
  data_t  m_data;
  int     m_sel, m_lock, m_rr;
  longint m_cnt [N];

  stream_arbiter #(
    .N_STREAMS (N),
    .DATA_TYPE (data_t)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_sel   (o_sel),
    .o_ready (o_ready)
`ifdef STREAM_ARBITER_STATS_EN
    ,
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which stream the rules say is granted right now; -1 if none.
  function automatic int model_grant();
    if (m_locked) return i_valid[m_lock] ? m_lock : -1;
    for (int off = 0; off < N; off++)
      if (i_valid[(m_rr + off) % N]) return (m_rr + off) % N;
    return -1;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin : model
    int g;
    if (rst) begin
      m_valid = 0; m_last = 0; m_locked = 0; m_sel = 0; m_lock = 0; m_rr = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      g = model_grant();
      if (!m_valid || o_ready) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_data = i_data[g];
          m_last = i_last[g];
          m_sel  = g;
          if (m_cnt[g] < 64'hFFFF_FFFF) m_cnt[g]++;
          if (i_last[g]) begin
            m_locked = 0;
            m_rr     = (g + 1) % N;
          end else begin
            m_locked = 1;
            m_lock   = g;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int g;
    logic [N-1:0] er;
    if (rst) begin
      check("rst_o_valid", o_valid, 0);
      check("rst_i_ready", i_ready, 0);
      check("rst_o_sel", o_sel, 0);
      check("rst_o_last", o_last, 0);
    end else begin
      g  = model_grant();
      er = '0;
      if (g >= 0 && (!m_valid || o_ready)) er[g] = 1'b1;
      check("i_ready", i_ready, er);
      check("o_valid", o_valid, m_valid);
      check("o_sel", o_sel, m_sel);
      check("o_last", o_last, m_last);
      if (m_valid) check("o_data", o_data, m_data);
      if (o_valid && o_ready) q_sel.push_back(int'(o_sel));
    end
`ifdef STREAM_ARBITER_STATS_EN
    for (int k = 0; k < N; k++)
      check("beat_count", beat_count[k], rst ? 64'd0 : m_cnt[k]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(string name);
    check({name, "_len"}, q_sel.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_sel.size(); i++)
      check(name, q_sel[i], exp_q[i]);
    q_sel.delete();
  endtask

  initial begin
    rst = 1; o_ready = 1; i_valid = '0; i_last = '0;
    for (int k = 0; k < N; k++) i_data[k] = '0;
    repeat (3) step();
    check("reset_o_valid", o_valid, 0);
    check("reset_i_ready", i_ready, 0);
    rst = 0;
    step();
    q_sel.delete();

    // All four streams single-beat: strict rotation, one beat per cycle.
    for (int k = 0; k < N; k++) i_data[k] = 64'h100 + 64'(k);
    i_last = '1; i_valid = '1;
    repeat (8) step();
    i_valid = '0;
    step(); step();
    exp_q = {0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("rr_single");

    // Stream 1 three-beat packet while stream 2 is always valid.
    i_valid = 4'b0110; i_last = 4'b0100;
    step();
    check("lock_ready_b2", i_ready, 4'b0010);
    step();
    i_last = 4'b0110;
    #1 check("lock_ready_b3", i_ready, 4'b0010);
    step();
    i_valid = 4'b0100;
    step(); step();
    i_valid = '0;
    step(); step();
    exp_q = {1, 1, 1, 2, 2};
    check_seq("packet_lock");

    // Stream 0 locked, drops valid for two cycles while stream 3 waits.
    i_valid = 4'b0001; i_last = 4'b0000;
    step();
    i_valid = 4'b1000; i_last = 4'b1000;
    step();
    check("gap_o_valid_1", o_valid, 0);
    step();
    check("gap_o_valid_2", o_valid, 0);
    i_valid = 4'b1001; i_last = 4'b1001;
    step();
    i_valid = 4'b1000;
    step();
    i_valid = '0;
    step(); step();
    exp_q = {0, 0, 3};
    check_seq("lock_gap");

    // Output held for five cycles with 0xA5 pending.
    i_data[1] = 64'hA5; i_valid = 4'b0010; i_last = 4'b1111;
    step();
    o_ready = 0; i_valid = 4'b1111;
    i_data[0] = {$urandom, $urandom};
    i_data[2] = {$urandom, $urandom};
    i_data[3] = {$urandom, $urandom};
    repeat (5) begin
      step();
      check("hold_o_data", o_data, 64'hA5);
      check("hold_i_ready", i_ready, 0);
    end
    o_ready = 1;
    step();
    check("resume_o_valid", o_valid, 1);
    check("resume_o_sel", o_sel, 2);
    check("resume_o_data", o_data, i_data[2]);
    i_valid = '0;
    step(); step();
    q_sel.delete();

    // Reset in the middle of a stream-2 packet.
    i_valid = 4'b0100; i_last = 4'b0000;
    step(); step();
    rst = 1;
    #1;
    check("rst_async_o_valid", o_valid, 0);
    check("rst_async_i_ready", i_ready, 0);
    i_valid = 4'b0101; i_last = 4'b0101;
    step(); step();
    rst = 0;
    step();
    check("post_rst_o_valid", o_valid, 1);
    check("post_rst_o_sel", o_sel, 0);
    i_valid = '0;
    step(); step();
    q_sel.delete();

`ifdef STREAM_ARBITER_STATS_EN
    rst = 1; step(); rst = 0; step();
    i_last = '1; i_valid = 4'b0010;
    repeat (10) step();
    i_valid = 4'b0001;
    repeat (3) step();
    i_valid = '0;
    step();
    check("stats_cnt1", beat_count[1], 10);
    check("stats_cnt0", beat_count[0], 3);
    rst = 1;
    #1;
    check("stats_rst_cnt1", beat_count[1], 0);
    check("stats_rst_cnt0", beat_count[0], 0);
    step(); rst = 0; step();
    q_sel.delete();
`endif

    // Randomized traffic with back-pressure and occasional reset.
    repeat (3000) begin
      for (int k = 0; k < N; k++) begin
        i_data[k] = {$urandom, $urandom};
        i_last[k] = ($urandom_range(2) == 0);
      end
      i_valid = N'($urandom);
      o_ready = ($urandom_range(3) != 0);
      if ($urandom_range(400) == 0) begin
        rst = 1; step(); step(); rst = 0;
      end
      step();
      if (q_sel.size() > 64) q_sel.delete();
    end
    i_valid = '0; o_ready = 1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
